// File: rtl/audio_tdm_port.sv
// ---------------------------------------------------------------------------
// audio_tdm_port
//
// Master-mode audio serial port for codec links. With NUM_SLOTS=2 the frame is
// standard I2S; larger even slot counts give a TDM frame. The port derives the
// bit clock and frame clock from i_clk, serialises one DAC sample per slot and
// deserialises one ADC sample per slot into a parallel per-frame word.
//
// Ports
//   i_clk            system clock
//   i_reset          asynchronous, active-high reset
//   iS_dac_data      per-slot DAC samples, slot s at [s*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   i_dac_valid      per-slot write strobe
//   o_dac_underrun   1-cycle pulse per slot that was not refreshed before frame load
//   o_frame_start    1-cycle pulse at frame load
//   oS_adc_data      last complete ADC frame, same slot packing as iS_dac_data
//   o_adc_valid      1-cycle pulse when oS_adc_data updates
//   o_bclk           bit clock
//   o_lrclk          frame clock (high in the second half of the frame)
//   o_dacData        serial DAC data, changes on bclk falling edges only
//   i_adcData        serial ADC data, already synchronised to i_clk
//   o_underrun_count 16-bit saturating underrun total (only with the macro)
//
// Build option
//   AUDIO_TDM_UNDERRUN_COUNT_EN  adds o_underrun_count.
// ---------------------------------------------------------------------------
module audio_tdm_port #(
  parameter int NUM_SLOTS    = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [NUM_SLOTS*SAMPLE_WIDTH-1:0] iS_dac_data,
  input  logic [NUM_SLOTS-1:0]              i_dac_valid,
  output logic [NUM_SLOTS-1:0]              o_dac_underrun,
  output logic                              o_frame_start,
  output logic [NUM_SLOTS*SAMPLE_WIDTH-1:0] oS_adc_data,
  output logic                              o_adc_valid,
  output logic                              o_bclk,
  output logic                              o_lrclk,
  output logic                              o_dacData,
  input  logic                              i_adcData
`ifdef AUDIO_TDM_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                       o_underrun_count
`endif
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int POS_W  = $clog2(SLOT_WIDTH);
  localparam int BIT_W  = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  // The frame bit counter is kept as a (slot, position-in-slot) pair so the
  // bit mapping needs no divider: bit_cnt = slot_q*SLOT_WIDTH + pos_q.
  logic [DIV_W-1:0]  div_q,  div_d;
  logic              bclk_q, bclk_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [POS_W-1:0]  pos_q,  pos_d;
  logic              lrclk_q, lrclk_d;
  logic              dac_bit_q, dac_bit_d;

  logic              tick, fall_ev, rise_ev, frame_load;
  logic              cur_mapped, nxt_mapped;
  logic [BIT_W-1:0]  cur_bit, nxt_bit;

  logic [NUM_SLOTS-1:0][SAMPLE_WIDTH-1:0] hold_q;      // latest DSP write per slot
  logic [NUM_SLOTS-1:0][SAMPLE_WIDTH-1:0] dac_frame_q; // frame being transmitted
  logic [NUM_SLOTS-1:0][SAMPLE_WIDTH-1:0] cap_q;       // ADC frame being captured
  logic [NUM_SLOTS-1:0][SAMPLE_WIDTH-1:0] adc_q;       // last published ADC frame
  logic [NUM_SLOTS-1:0]                   fresh_q;
  logic [NUM_SLOTS-1:0]                   underrun_q;
  logic                                   frame_start_q;
  logic                                   adc_valid_q;
  logic                                   adc_primed_q;

  always_comb begin
    tick       = (div_q == DIV_W'(BCLK_DIV - 1));
    div_d      = tick ? '0 : div_q + 1'b1;
    bclk_d     = tick ? ~bclk_q : bclk_q;
    fall_ev    = tick & bclk_q;
    rise_ev    = tick & ~bclk_q;
    frame_load = fall_ev && (slot_q == SLOT_W'(NUM_SLOTS - 1)) &&
                 (pos_q == POS_W'(SLOT_WIDTH - 1));

    slot_d = slot_q;
    pos_d  = pos_q;
    if (fall_ev) begin
      if (pos_q == POS_W'(SLOT_WIDTH - 1)) begin
        pos_d  = '0;
        slot_d = (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end

    lrclk_d = (slot_d >= SLOT_W'(NUM_SLOTS / 2));

    // Position p in 1..SAMPLE_WIDTH carries sample bit k=p-1 (k=0 is the MSB,
    // one bclk after the slot boundary), i.e. vector index SAMPLE_WIDTH-p.
    cur_mapped = (pos_q != '0) && (int'(pos_q) <= SAMPLE_WIDTH);
    nxt_mapped = (pos_d != '0) && (int'(pos_d) <= SAMPLE_WIDTH);
    cur_bit    = BIT_W'(SAMPLE_WIDTH - int'(pos_q));
    nxt_bit    = BIT_W'(SAMPLE_WIDTH - int'(pos_d));
    dac_bit_d  = nxt_mapped ? dac_frame_q[slot_d][nxt_bit] : 1'b0;
  end

  // i_dac_valid is a plain write strobe with no backpressure: a slot is written
  // on every cycle its bit is high, the last write before a frame load is the
  // one transmitted, and a write sampled on the load edge itself lands after
  // the load (it counts for the following frame).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_q         <= '0;
      bclk_q        <= 1'b0;
      slot_q        <= SLOT_W'(NUM_SLOTS - 1);
      pos_q         <= POS_W'(SLOT_WIDTH - 1);
      lrclk_q       <= 1'b0;
      dac_bit_q     <= 1'b0;
      hold_q        <= '0;
      dac_frame_q   <= '0;
      cap_q         <= '0;
      adc_q         <= '0;
      fresh_q       <= '0;
      underrun_q    <= '0;
      frame_start_q <= 1'b0;
      adc_valid_q   <= 1'b0;
      adc_primed_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      slot_q        <= slot_d;
      pos_q         <= pos_d;
      frame_start_q <= frame_load;
      adc_valid_q   <= frame_load & adc_primed_q;
      underrun_q    <= frame_load ? ~fresh_q : '0;

      if (fall_ev) begin
        lrclk_q   <= lrclk_d;
        dac_bit_q <= dac_bit_d;
      end

      if (rise_ev && cur_mapped) begin
        cap_q[slot_q][cur_bit] <= i_adcData;
      end

      if (frame_load) begin
        dac_frame_q  <= hold_q;
        fresh_q      <= '0;
        adc_primed_q <= 1'b1;
        // The partial frame captured before the first load is discarded.
        if (adc_primed_q) begin
          adc_q <= cap_q;
        end
      end

      // Placed after the load clear so a coincident write keeps fresh set.
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (i_dac_valid[s]) begin
          hold_q[s]  <= iS_dac_data[s*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          fresh_q[s] <= 1'b1;
        end
      end
    end
  end

`ifdef AUDIO_TDM_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q;
  logic [16:0] ucnt_sum;

  // Adds the underrun flags produced by this load; bit 16 signals overflow.
  always_comb begin
    ucnt_sum = {1'b0, ucnt_q};
    for (int s = 0; s < NUM_SLOTS; s++) begin
      ucnt_sum = ucnt_sum + {16'd0, ~fresh_q[s]};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ucnt_q <= '0;
    end else if (frame_load) begin
      ucnt_q <= ucnt_sum[16] ? 16'hFFFF : ucnt_sum[15:0];
    end
  end

  assign o_underrun_count = ucnt_q;
`endif

  assign o_bclk         = bclk_q;
  assign o_lrclk        = lrclk_q;
  assign o_dacData      = dac_bit_q;
  assign o_frame_start  = frame_start_q;
  assign o_dac_underrun = underrun_q;
  assign o_adc_valid    = adc_valid_q;
  assign oS_adc_data    = adc_q;

endmodule
